// File: rtl/rf_int_ctrl.sv
// rtl/rf_int_ctrl.sv - interrupt sequencer driving register-file shadow-bank save/restore
// Takes interrupts at instruction boundaries, pulses save/load to the RF and redirects the PC.
module rf_int_ctrl #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_en,
  input  logic               instr_done,
  input  logic               is_mret,
  input  logic [31:0]        pc_next,
  output logic               save_out,
  output logic               load_out,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               stall,
  output logic               in_isr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [31:0]        epc
);

  localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, SAVE, ISR, RESTORE} state_t;

  state_t          state;
  logic [ID_W-1:0] id;
  logic            accept;

  function automatic logic [ID_W-1:0] low_idx(input logic [NUM_IRQ-1:0] req);
    low_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) low_idx = ID_W'(i);
    end
  endfunction

  // Evaluated on current inputs, so irq_en dropping on the boundary blocks the accept.
  assign accept = irq_en && (|irq) && instr_done && !is_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc   <= '0;
      id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SAVE;
            epc   <= pc_next;
            id    <= low_idx(irq);
          end
        end
        SAVE:    state <= ISR;
        ISR:     if (instr_done && is_mret) state <= RESTORE;
        RESTORE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    save_out    = 1'b0;
    load_out    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    stall       = 1'b0;
    in_isr      = 1'b0;
    irq_ack     = '0;
    case (state)
      SAVE: begin
        save_out    = 1'b1;
        stall       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = VEC_BASE + (32'(id) << VEC_SHIFT);
        irq_ack[id] = 1'b1;
      end
      ISR: in_isr = 1'b1;
      RESTORE: begin
        load_out    = 1'b1;
        stall       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_int_ctrl.sv
// tb/tb_rf_int_ctrl.sv - directed vector table plus randomized run against a reference model
module tb_rf_int_ctrl;

  logic        clk = 1'b0;
  logic        rst, irq_en, instr_done, is_mret;
  logic [3:0]  irq;
  logic [31:0] pc_next;
  logic        save_out, load_out, pc_redirect, stall, in_isr;
  logic [31:0] pc_target, epc;
  logic [3:0]  irq_ack;

  int n_cmp = 0;
  int n_bad = 0;

  rf_int_ctrl #(.NUM_IRQ(4), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .instr_done(instr_done),
    .is_mret(is_mret), .pc_next(pc_next), .save_out(save_out), .load_out(load_out),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .stall(stall), .in_isr(in_isr),
    .irq_ack(irq_ack), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        en, done, mret;
    logic [31:0] pc;
    logic        save, load, isr;
    logic [3:0]  ack;
    logic [31:0] tgt, epc;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic e, input logic d,
                              input logic m, input logic [31:0] p, input logic s, input logic l,
                              input logic i, input logic [3:0] a, input logic [31:0] t,
                              input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.irq = q; v.en = e; v.done = d; v.mret = m; v.pc = p;
    v.save = s; v.load = l; v.isr = i; v.ack = a; v.tgt = t; v.epc = ep;
    tv.push_back(v);
  endfunction

  // Reference model: a handler flag plus a pending one-cycle pulse (0 none, 1 save, 2 restore).
  bit          m_hnd;
  int          m_pulse;
  logic [31:0] m_epc, m_vec;
  logic [3:0]  m_ack;

  task automatic model_step();
    int k;
    if (rst) begin
      m_hnd = 0; m_pulse = 0; m_epc = 0;
    end else if (m_pulse == 1) begin
      m_pulse = 0; m_hnd = 1;
    end else if (m_pulse == 2) begin
      m_pulse = 0; m_hnd = 0;
    end else if (!m_hnd) begin
      if (irq_en && irq != 0 && instr_done && !is_mret) begin
        k = 0;
        while (!irq[k]) k++;
        m_ack   = 4'(1 << k);
        m_vec   = 32'h100 + 32'(k * 16);
        m_epc   = pc_next;
        m_pulse = 1;
      end
    end else if (instr_done && is_mret) begin
      m_pulse = 2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic s, input logic l, input logic i,
                           input logic [3:0] a, input logic [31:0] t, input logic [31:0] ep);
    chk({tag, " save_out"}, 32'(save_out), 32'(s));
    chk({tag, " load_out"}, 32'(load_out), 32'(l));
    chk({tag, " pc_redirect"}, 32'(pc_redirect), 32'(s | l));
    chk({tag, " stall"}, 32'(stall), 32'(s | l));
    chk({tag, " in_isr"}, 32'(in_isr), 32'(i));
    chk({tag, " irq_ack"}, 32'(irq_ack), 32'(a));
    chk({tag, " pc_target"}, pc_target, t);
    chk({tag, " epc"}, epc, ep);
  endtask

  task automatic apply(input logic r, input logic [3:0] q, input logic e, input logic d,
                       input logic m, input logic [31:0] p);
    rst = r; irq = q; irq_en = e; instr_done = d; is_mret = m; pc_next = p;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; irq = '0; irq_en = 1'b0; instr_done = 1'b0; is_mret = 1'b0; pc_next = '0;
    m_hnd = 0; m_pulse = 0; m_epc = 0; m_vec = 0; m_ack = 0;

    //   rst irq    en d  m  pc             save load isr ack    target         epc
    add(1, 4'b0000, 0, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h0);
    add(1, 4'b0000, 0, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h0);
    for (int i = 0; i < 10; i++)
      add(0, 4'b0000, 1, 1, 0, 32'h10,     0, 0, 0, 4'b0000, 32'h0,   32'h0);
    add(0, 4'b0000, 1, 1, 1, 32'h14,       0, 0, 0, 4'b0000, 32'h0,   32'h0);
    // single round trip
    add(0, 4'b0100, 1, 1, 0, 32'h40,       1, 0, 0, 4'b0100, 32'h120, 32'h40);
    add(0, 4'b0100, 1, 0, 0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,   32'h40);
    add(0, 4'b0101, 1, 1, 0, 32'h124,      0, 0, 1, 4'b0000, 32'h0,   32'h40);
    add(0, 4'b0001, 1, 1, 0, 32'h128,      0, 0, 1, 4'b0000, 32'h0,   32'h40);
    add(0, 4'b0001, 1, 1, 0, 32'h12c,      0, 0, 1, 4'b0000, 32'h0,   32'h40);
    add(0, 4'b0000, 1, 1, 1, 32'h99,       0, 1, 0, 4'b0000, 32'h40,  32'h40);
    add(0, 4'b0000, 1, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h40);
    // priority, then loser taken after return
    add(0, 4'b1010, 1, 1, 0, 32'h200,      1, 0, 0, 4'b0010, 32'h110, 32'h200);
    add(0, 4'b1010, 1, 0, 0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,   32'h200);
    add(0, 4'b1000, 1, 1, 1, 32'h0,        0, 1, 0, 4'b0000, 32'h200, 32'h200);
    add(0, 4'b1000, 1, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h200);
    add(0, 4'b1000, 1, 1, 0, 32'h300,      1, 0, 0, 4'b1000, 32'h130, 32'h300);
    add(0, 4'b1000, 1, 0, 0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,   32'h300);
    add(0, 4'b0001, 1, 1, 1, 32'h0,        0, 1, 0, 4'b0000, 32'h300, 32'h300);
    add(0, 4'b0001, 1, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h300);
    // masked boundaries, unqualified boundary, mret blocks accept
    for (int i = 0; i < 5; i++)
      add(0, 4'b1111, 0, 1, 0, 32'h50,     0, 0, 0, 4'b0000, 32'h0,   32'h300);
    add(0, 4'b0001, 1, 0, 0, 32'h54,       0, 0, 0, 4'b0000, 32'h0,   32'h300);
    add(0, 4'b0001, 1, 1, 1, 32'h58,       0, 0, 0, 4'b0000, 32'h0,   32'h300);
    // reset in ISR aborts the sequence
    add(0, 4'b0001, 1, 1, 0, 32'h80,       1, 0, 0, 4'b0001, 32'h100, 32'h80);
    add(0, 4'b0000, 1, 0, 0, 32'h0,        0, 0, 1, 4'b0000, 32'h0,   32'h80);
    add(1, 4'b0000, 1, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h0);
    add(0, 4'b0000, 1, 1, 1, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h0);
    add(0, 4'b0000, 1, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0,   32'h0);

    foreach (tv[i]) begin
      apply(tv[i].rst, tv[i].irq, tv[i].en, tv[i].done, tv[i].mret, tv[i].pc);
      check_all($sformatf("row%0d", i), tv[i].save, tv[i].load, tv[i].isr,
                tv[i].ack, tv[i].tgt, tv[i].epc);
    end

    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), $urandom);
      check_all($sformatf("rnd%0d", c), (m_pulse == 1), (m_pulse == 2),
                (m_hnd && m_pulse == 0), (m_pulse == 1) ? m_ack : 4'b0000,
                (m_pulse == 1) ? m_vec : (m_pulse == 2) ? m_epc : 32'h0, m_epc);
      chk($sformatf("rnd%0d save_load_excl", c), 32'(save_out & load_out), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
